// File: rtl/input_debounce_pkg.sv
// ---------------------------------------------------------------------------
// input_debounce_pkg
//
// Purpose: shared constants for the input conditioning stage that sits
// between the board pins and main. Holds the default channel counts and the
// default debounce window (1 ms at the 125 MHz system clock).
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package input_debounce_pkg;

  localparam int SYSCLK_HZ               = 125000000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 125000;
  localparam int N_BTN_DEFAULT           = 4;
  localparam int N_SW_DEFAULT            = 2;

endpackage

// File: rtl/input_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//
// Purpose: one input conditioning channel. A raw asynchronous pin is brought
// into the sysclk domain with a two-flop synchroniser (s1, s2) and a new level
// is accepted into db only after s2 has disagreed with db for
// DEBOUNCE_CYCLES consecutive cycles. Any return to the accepted level
// restarts qualification.
//
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN
//   defined   -> rise/fall are registered one-cycle pulses that coincide with
//                the cycle in which db has just changed 0->1 / 1->0.
//   undefined -> no edge registers; rise/fall are tied to 0.
//
// Ports:
//   sysclk  in   system clock, all logic on posedge
//   rst     in   asynchronous active-high reset
//   raw     in   raw asynchronous pin
//   db      out  debounced level
//   rise    out  one-cycle pulse on debounced 0->1
//   fall    out  one-cycle pulse on debounced 1->0
// ---------------------------------------------------------------------------
module debounce_bit
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic sysclk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Two-flop synchroniser. s1 may go metastable; only s2 is used downstream.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // The new level is taken on the cycle where s2 still disagrees with db and
  // the counter has already seen DEBOUNCE_CYCLES-1 disagreeing cycles.
  assign accept = (s2 != db) && (cnt == CNT_LAST);

  // Stability counter and accepted level. The counter only climbs while s2
  // differs from db and is cleared on acceptance, so it can never wrap.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      db  <= s2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  // Edge pulses are computed from the same acceptance condition as db so
  // they go high on exactly the edge where db changes and last one cycle.
  // A single acceptance moves db one way only, so rise and fall never meet.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
    end
  end
`else
  // Edge detection not built; the outputs stay present but constant.
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//
// Purpose: input conditioning stage between the board pins and main.
// Synchronises and debounces the raw push-buttons and slide switches into the
// sysclk domain. main consumes btn_db/sw_db in place of the raw pins; each
// accepted change appears DEBOUNCE_CYCLES+2 cycles after the raw pin moved.
//
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN
//   defined   -> btn_rise/btn_fall carry one-cycle press/release pulses.
//   undefined -> btn_rise/btn_fall are constant 0. Level outputs unchanged.
//
// Ports:
//   sysclk    in   system clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   btn       in   raw button pins [N_BTN]
//   sw        in   raw switch pins [N_SW]
//   btn_db    out  debounced button levels
//   sw_db     out  debounced switch levels
//   btn_rise  out  one-cycle pulse on debounced button 0->1 (press)
//   btn_fall  out  one-cycle pulse on debounced button 1->0 (release)
// ---------------------------------------------------------------------------
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
);

  // One independent channel per button; presses and releases on different
  // buttons qualify separately and their pulses may coincide.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .sysclk(sysclk),
      .rst   (rst),
      .raw   (btn[i]),
      .db    (btn_db[i]),
      .rise  (btn_rise[i]),
      .fall  (btn_fall[i])
    );
  end

  // Switches only need clean levels, so their edge outputs go nowhere.
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .sysclk(sysclk),
      .rst   (rst),
      .raw   (sw[i]),
      .db    (sw_db[i]),
      .rise  (),
      .fall  ()
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//
// Directed bench for input_debounce with DEBOUNCE_CYCLES = 4. Inputs change on
// the falling edge; outputs are sampled 1 ns after a rising edge. A raw change
// made just before edge k is captured in s1 at edge k and reaches db at edge
// k+5, so it is visible at the 6th sample after the change.
// Edge pulse expectations follow INPUT_DEBOUNCE_EDGE_EN (0 when undefined).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_input_debounce;

  localparam int N_BTN = 4;
  localparam int N_SW  = 2;
  localparam int DC    = 4;
  localparam int LAT   = DC + 2;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             sysclk;
  logic             rst;
  logic [N_BTN-1:0] btn;
  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn_db;
  logic [N_SW-1:0]  sw_db;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;

  int checks = 0;
  int errors = 0;

  input_debounce #(
    .N_BTN          (N_BTN),
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .btn     (btn),
    .sw      (sw),
    .btn_db  (btn_db),
    .sw_db   (sw_db),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  // 100 MHz free-running clock.
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive new raw pin values on the falling edge.
  task automatic applyStimulus(input logic [N_BTN-1:0] b, input logic [N_SW-1:0] s);
    @(negedge sysclk);
    btn = b;
    sw  = s;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Expected edge pulse: the given mask on the acceptance sample, else 0.
  function automatic logic [N_BTN-1:0] pulse(input int n, input logic [N_BTN-1:0] mask);
    return (EDGE_EN && n == LAT) ? mask : '0;
  endfunction

  initial begin
    rst = 1'b1;
    btn = 4'hF;
    sw  = 2'b11;

    // Reset with all inputs high: everything held at zero.
    waitEdges(3);
    checkOutput("rst_btn_db",   32'(btn_db),   32'h0);
    checkOutput("rst_sw_db",    32'(sw_db),    32'h0);
    checkOutput("rst_btn_rise", 32'(btn_rise), 32'h0);
    checkOutput("rst_btn_fall", 32'(btn_fall), 32'h0);

    // Release: inputs held high are re-qualified from zero.
    @(negedge sysclk);
    rst = 1'b0;
    for (int n = 1; n <= LAT + 1; n++) begin
      waitEdges(1);
      checkOutput("rel_btn_db",   32'(btn_db),   (n >= LAT) ? 32'hF : 32'h0);
      checkOutput("rel_sw_db",    32'(sw_db),    (n >= LAT) ? 32'h3 : 32'h0);
      checkOutput("rel_btn_rise", 32'(btn_rise), 32'(pulse(n, 4'hF)));
      checkOutput("rel_btn_fall", 32'(btn_fall), 32'h0);
    end

    // Drop every input: all buttons release together.
    applyStimulus(4'h0, 2'b00);
    for (int n = 1; n <= LAT + 1; n++) begin
      waitEdges(1);
      checkOutput("off_btn_db",   32'(btn_db),   (n >= LAT) ? 32'h0 : 32'hF);
      checkOutput("off_sw_db",    32'(sw_db),    (n >= LAT) ? 32'h0 : 32'h3);
      checkOutput("off_btn_fall", 32'(btn_fall), 32'(pulse(n, 4'hF)));
      checkOutput("off_btn_rise", 32'(btn_rise), 32'h0);
    end
    waitEdges(3);

    // Clean press on btn[0].
    applyStimulus(4'b0001, 2'b00);
    for (int n = 1; n <= LAT + 2; n++) begin
      waitEdges(1);
      checkOutput("press_btn_db",   32'(btn_db),   (n >= LAT) ? 32'h1 : 32'h0);
      checkOutput("press_btn_rise", 32'(btn_rise), 32'(pulse(n, 4'b0001)));
      checkOutput("press_btn_fall", 32'(btn_fall), 32'h0);
    end

    // Bounce on btn[1]: 1,0,1,0 each held 2 cycles, never long enough.
    for (int i = 0; i < 4; i++) begin
      applyStimulus({2'b00, (i % 2 == 0), 1'b1}, 2'b00);
      for (int c = 0; c < 2; c++) begin
        waitEdges(1);
        checkOutput("bounce_btn_db",   32'(btn_db),   32'h1);
        checkOutput("bounce_btn_rise", 32'(btn_rise), 32'h0);
        checkOutput("bounce_btn_fall", 32'(btn_fall), 32'h0);
      end
    end
    // Settle at 1: accepted a full latency after the last transition.
    applyStimulus(4'b0011, 2'b00);
    for (int n = 1; n <= LAT + 1; n++) begin
      waitEdges(1);
      checkOutput("settle_btn_db",   32'(btn_db),   (n >= LAT) ? 32'h3 : 32'h1);
      checkOutput("settle_btn_rise", 32'(btn_rise), 32'(pulse(n, 4'b0010)));
      checkOutput("settle_btn_fall", 32'(btn_fall), 32'h0);
    end

    // Glitch of 3 cycles on sw[0] is rejected.
    applyStimulus(4'b0011, 2'b01);
    repeat (3) @(posedge sysclk);
    applyStimulus(4'b0011, 2'b00);
    for (int n = 1; n <= 10; n++) begin
      waitEdges(1);
      checkOutput("glitch_sw_db", 32'(sw_db), 32'h0);
    end

    // Reset arriving mid-qualification clears counter and levels at once.
    applyStimulus(4'b0011, 2'b11);
    waitEdges(2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_sw_db",  32'(sw_db),  32'h0);
    checkOutput("midrst_btn_db", 32'(btn_db), 32'h0);
    checkOutput("midrst_cnt0",   32'(dut.g_sw[0].u_bit.cnt), 32'h0);
    checkOutput("midrst_cnt1",   32'(dut.g_sw[1].u_bit.cnt), 32'h0);
    waitEdges(1);
    checkOutput("midrst_hold_sw_db", 32'(sw_db), 32'h0);
    @(negedge sysclk);
    rst = 1'b0;
    for (int n = 1; n <= LAT + 1; n++) begin
      waitEdges(1);
      checkOutput("post_sw_db",    32'(sw_db),    (n >= LAT) ? 32'h3 : 32'h0);
      checkOutput("post_btn_db",   32'(btn_db),   (n >= LAT) ? 32'h3 : 32'h0);
      checkOutput("post_btn_rise", 32'(btn_rise), 32'(pulse(n, 4'b0011)));
      checkOutput("post_btn_fall", 32'(btn_fall), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Input conditioning stage between the board pins and `main`. Synchronises and debounces the raw push-buttons `btn[3:0]` and slide switches `sw[1:0]` into the `sysclk` domain. Presents clean levels to `main` and, optionally, single-cycle press/release pulses for the buttons. `main` consumes the debounced `sw_db`/`btn_db` in place of the raw pins.

## Interface
- `N_BTN`, default 4, number of button inputs
- `N_SW`, default 2, number of switch inputs
- `DEBOUNCE_CYCLES`, default 125000 (1 ms at 125 MHz), number of consecutive stable cycles needed to accept a new level; legal range ≥ 1
- `sysclk  in  1  system clock, all logic on posedge`
- `rst  in  1  reset, asynchronous, active-high`
- `btn  in  N_BTN  raw asynchronous button pins`
- `sw  in  N_SW  raw asynchronous switch pins`
- `btn_db  out  N_BTN  debounced button levels`
- `sw_db  out  N_SW  debounced switch levels`
- `btn_rise  out  N_BTN  one-cycle pulse on debounced 0→1 (press)`
- `btn_fall  out  N_BTN  one-cycle pulse on debounced 1→0 (release)`

## Operation
- Each input bit is handled independently by an identical channel.
- Each channel has a 2-flop synchroniser, `s1` then `s2`, driven by the raw pin.
- Each channel holds a stable counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)` and a registered output `db`.
- At each posedge, if `s2 == db`, then `cnt <= 0`. Any bounce back to the accepted level restarts qualification.
- At each posedge, if `s2 != db` and `cnt < DEBOUNCE_CYCLES-1`, then `cnt <= cnt+1`.
- At each posedge, if `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
- The counter never wraps and saturates by construction.
- `btn_rise[i]` is registered and is high for exactly the one cycle in which `btn_db[i]` has just changed 0→1. `btn_fall[i]` is the same for 1→0.
- Rise and fall for one bit are mutually exclusive.
- Simultaneous changes on several bits are qualified independently. Their pulses may coincide.
- There are no edge pulses for switches.

## Timing
- All outputs reset to 0: `btn_db`, `sw_db`, `btn_rise`, `btn_fall`. `s1`, `s2` and `cnt` also reset to 0.
- Let a raw level be first captured into `s1` at edge k and then held steady.
- `db` takes the new value at edge k+1+`DEBOUNCE_CYCLES`. With `DEBOUNCE_CYCLES`=1 this is edge k+2.
- The corresponding `btn_rise`/`btn_fall` is high from edge k+1+`DEBOUNCE_CYCLES` to the next edge.
- A raw glitch shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s2`, never changes `db`.
- Reset asserted mid-qualification clears everything immediately.
- An input held at 1 through reset release is re-qualified from zero after release. It reaches `db`=1 after the full latency, and a button in that case produces a `btn_rise`.
- The downstream `main` sees debounced switch changes `DEBOUNCE_CYCLES`+2 cycles later than raw. Any bench checking `main` end-to-end must wait for this.

## Configuration
- Macro `INPUT_DEBOUNCE_EDGE_EN`.
- When defined, the edge detect registers are built and `btn_rise`/`btn_fall` behave as above.
- When undefined, no edge registers are built. `btn_rise` and `btn_fall` are tied to constant 0, and the ports remain present.
- Level outputs are identical either way.

## Structure
- Package `input_debounce_pkg` holds:
  - `DEBOUNCE_CYCLES_DEFAULT` = 125000
  - `SYSCLK_HZ` = 125000000
  - `N_BTN_DEFAULT` = 4
  - `N_SW_DEFAULT` = 2
- Sub-module `debounce_bit` contains one channel: the synchroniser, `cnt` and `db`, plus the edge outputs under the macro.
- `input_debounce` instantiates `N_BTN` + `N_SW` copies of `debounce_bit` in generate loops.
- `debounce_bit` instances for switches leave their edge outputs unconnected.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and the macro defined unless stated.
- Reset: hold `rst`=1 with `btn`=4'hF and `sw`=2'b11 → all outputs 0. Release → `btn_db`=4'hF and `sw_db`=2'b11 at edge k+5 after first capture. `btn_rise`=4'hF for one cycle.
- Clean press: `btn[0]` 0→1 held → `btn_db[0]`=1 exactly 5 edges after `s1` capture. `btn_rise[0]` pulse of width 1. `btn_fall`=0 throughout.
- Bounce: `btn[1]` toggles 1,0,1,0 with 2-cycle periods and then settles at 1 → `btn_db[1]` stays 0 during toggling. It rises 5 edges after the last transition, with a single `btn_rise[1]`.
- Glitch reject: `sw[0]` pulses high for 3 cycles → `sw_db[0]` remains 0.
- Reset mid-qualification: `sw` changes 00→11 and `rst` pulses 2 edges later → `sw_db`=00 and `cnt`=0. After release, `sw_db`=11 at the full latency.
- Macro undefined: repeat the clean press → `btn_db[0]` behaves the same, and `btn_rise`/`btn_fall` stay 0 throughout.
